// File: rtl/widget_cmd_sequencer_if.sv
// widget_cmd_sequencer_if: command and response channels between a host and the sequencer.
//   cmd_valid/cmd_ready          command handshake
//   cmd_opcode/id/addr/data      command payload (32 bits each)
//   rsp_valid/rsp_ready          response handshake
//   rsp_data/rsp_err             response payload
// The master modport is the host side and the slave modport is the sequencer side.
interface widget_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_opcode;
    logic [31:0] cmd_id;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_opcode, cmd_id, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_id, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/widget_cmd_sequencer.sv
// widget_cmd_sequencer: buffers host commands and issues them one at a time to the widget driver.
//   clock       single clock, rising edge
//   reset       asynchronous, active-low
//   cmd         slave side of the command/response interface
//   drv_opcode  to driver opcode (0 = harmless ping when idle)
//   drv_id      to driver register id
//   drv_in      to driver write data
//   drv_addr    to driver word address
//   drv_out     from driver, combinational in drv_*
//   busy        FIFO non-empty or a command in flight
//   err_count   saturating count of rejected commands
module widget_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int NUM_IDS = 3,
    parameter int ERR_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    widget_cmd_sequencer_if.slave cmd,
    output logic [31:0]          drv_opcode,
    output logic [31:0]          drv_id,
    output logic [31:0]          drv_in,
    output logic [31:0]          drv_addr,
    input  logic [31:0]          drv_out,
    output logic                 busy,
    output logic [ERR_W-1:0]     err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    logic [127:0]     fifo_q [DEPTH];
    logic [127:0]     fifo_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [1:0]       state_q, state_d;
    logic [31:0]      iss_op_q, iss_op_d, iss_id_q, iss_id_d;
    logic [31:0]      iss_addr_q, iss_addr_d, iss_data_q, iss_data_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             push, pop, hs, iss_ok, drive;

    always_comb begin
        iss_ok = iss_op_q <= 32'd2 && (iss_op_q == 32'd0 || iss_id_q < 32'(NUM_IDS));
        drive  = state_q == ISSUE && iss_ok;
        push   = cmd.cmd_valid && cmd_ready_q;
        hs     = rsp_valid_q && cmd.rsp_ready;
        // Only entries already stored can be popped: no same-cycle bypass.
        pop    = count_q != '0 && (state_q == IDLE || (state_q == RESPOND && hs));
        fifo_d = fifo_q;
        if (push) fifo_d[wr_ptr_q] = {cmd.cmd_opcode, cmd.cmd_id, cmd.cmd_addr, cmd.cmd_data};
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
        cmd_ready_d = count_d != (AW+1)'(DEPTH);
        state_d     = state_q == ISSUE ? RESPOND :
                      pop ? ISSUE :
                      (state_q == RESPOND && hs) ? IDLE : state_q;
        {iss_op_d, iss_id_d, iss_addr_d, iss_data_d} =
            pop ? fifo_q[rd_ptr_q] : {iss_op_q, iss_id_q, iss_addr_q, iss_data_q};
        // The response lands at the end of the single ISSUE cycle, sampling drv_out live.
        rsp_valid_d = state_q == ISSUE ? 1'b1 : hs ? 1'b0 : rsp_valid_q;
        rsp_err_d   = state_q == ISSUE ? !iss_ok : rsp_err_q;
        rsp_data_d  = state_q != ISSUE ? rsp_data_q :
                      (iss_ok && iss_op_q != 32'd1) ? drv_out : 32'd0;
        err_count_d = (state_q == ISSUE && !iss_ok && !(&err_count_q)) ?
                      err_count_q + ERR_W'(1) : err_count_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= IDLE;
            iss_op_q    <= '0;
            iss_id_q    <= '0;
            iss_addr_q  <= '0;
            iss_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            err_count_q <= '0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            state_q     <= state_d;
            iss_op_q    <= iss_op_d;
            iss_id_q    <= iss_id_d;
            iss_addr_q  <= iss_addr_d;
            iss_data_q  <= iss_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            err_count_q <= err_count_d;
        end
    end

    // Rejected commands never reach the driver: drv_* stay at the idle ping.
    assign drv_opcode    = drive ? iss_op_q : 32'd0;
    assign drv_id        = drive ? iss_id_q : 32'd0;
    assign drv_addr      = drive ? iss_addr_q : 32'd0;
    assign drv_in        = drive ? iss_data_q : 32'd0;
    assign cmd.cmd_ready = cmd_ready_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_data  = rsp_data_q;
    assign cmd.rsp_err   = rsp_err_q;
    assign busy          = count_q != '0 || state_q != IDLE;
    assign err_count     = err_count_q;
endmodule
